// File: rtl/tub_dac_pkg.sv
// Shared definitions for the TUB threshold DAC serial loader.
// Frame layout, FSM state encoding and frame builder.
package tub_dac_pkg;

    localparam int FRAME_W = 16;
    localparam int CH_BIT  = 15;
    localparam int CODE_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        LATCH,
        FIN
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(
        input logic              ch,
        input logic [CODE_W-1:0] code
    );
        logic [FRAME_W-1:0] f;
        f             = '0;
        f[CH_BIT]     = ch;
        f[CODE_W-1:0] = code;
        return f;
    endfunction

endpackage

// File: rtl/tub_dac_tick.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks.
// A start pulse realigns the count so the first tick lands CLK_DIV cycles later.
module tub_dac_tick
    import tub_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (start_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tub_dac_loader.sv
// Serial loader for the dual 12-bit threshold DAC feeding the lt1364 buffers.
// Shifts {CH,000,code} MSB-first, then strobes the DAC latch.
module tub_dac_loader
    import tub_dac_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic                  CH,
    input  logic [DATA_WIDTH-1:0] DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERRUN,
    output logic                  DAC_SCLK,
    output logic                  DAC_SDI,
    output logic                  DAC_CS_N,
    output logic                  DAC_LD_N
);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   sh_q, sh_d;
    logic [3:0]           bit_q, bit_d;
    logic                 sclk_q, sclk_d;
    logic                 ovr_q, ovr_d;
    logic                 tick;
    logic                 accept;
    logic [CODE_W-1:0]    code;

    always_comb begin
        code                 = '0;
        code[DATA_WIDTH-1:0] = DATA;
    end

    // FIN accepts a new request so transfers can run back to back
    assign accept = LOAD && ((state_q == IDLE) || (state_q == FIN));

    tub_dac_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (accept),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        ovr_d   = ovr_q | (LOAD & BUSY);
        unique case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = SHIFT;
                    sh_d    = make_frame(CH, code);
                    bit_d   = 4'd15;
                    sclk_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // data advances only as SCLK falls
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d = GAP;
                        end else begin
                            bit_d = bit_q - 4'd1;
                            sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            GAP: begin
                if (tick) state_d = LATCH;
            end
            LATCH: begin
                if (tick) state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign BUSY     = (state_q == SHIFT) || (state_q == GAP) || (state_q == LATCH);
    assign DONE     = (state_q == FIN);
    assign OVERRUN  = ovr_q;
    assign DAC_SCLK = sclk_q;
    assign DAC_SDI  = (state_q == SHIFT) && sh_q[FRAME_W-1];
    assign DAC_CS_N = (state_q != SHIFT);
    assign DAC_LD_N = (state_q != LATCH);

endmodule

// File: tb/tb_tub_dac_loader.sv
// Directed bench for tub_dac_loader: CLK_DIV=4 and CLK_DIV=1 instances
// side by side, per-cycle monitor of the serial bus.
module tb_tub_dac_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        load_a = 1'b0, ch_a = 1'b0;
    logic [11:0] data_a = '0;
    logic        load_b = 1'b0, ch_b = 1'b0;
    logic [11:0] data_b = '0;

    logic busy_a, done_a, ovr_a, sclk_a, sdi_a, csn_a, ldn_a;
    logic busy_b, done_b, ovr_b, sclk_b, sdi_b, csn_b, ldn_b;

    logic sel = 1'b0;
    logic o_busy, o_done, o_ovr, o_sclk, o_sdi, o_csn, o_ldn;

    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_ovr  = sel ? ovr_b  : ovr_a;
    assign o_sclk = sel ? sclk_b : sclk_a;
    assign o_sdi  = sel ? sdi_b  : sdi_a;
    assign o_csn  = sel ? csn_b  : csn_a;
    assign o_ldn  = sel ? ldn_b  : ldn_a;

    tub_dac_loader #(.DATA_WIDTH(12), .CLK_DIV(4)) u_dut_a (
        .CLK(CLK), .RST(RST), .LOAD(load_a), .CH(ch_a), .DATA(data_a),
        .BUSY(busy_a), .DONE(done_a), .OVERRUN(ovr_a),
        .DAC_SCLK(sclk_a), .DAC_SDI(sdi_a), .DAC_CS_N(csn_a), .DAC_LD_N(ldn_a)
    );

    tub_dac_loader #(.DATA_WIDTH(12), .CLK_DIV(1)) u_dut_b (
        .CLK(CLK), .RST(RST), .LOAD(load_b), .CH(ch_b), .DATA(data_b),
        .BUSY(busy_b), .DONE(done_b), .OVERRUN(ovr_b),
        .DAC_SCLK(sclk_b), .DAC_SDI(sdi_b), .DAC_CS_N(csn_b), .DAC_LD_N(ldn_b)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    int          cyc;
    logic [15:0] bits;
    int          nrise, ntog;
    int          cs_first, cs_last, cs_cnt;
    int          ld_first, ld_last, ld_cnt;
    int          done_first, done_last, done_n;
    logic        prev_sclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clr();
        cyc = 0; bits = '0; nrise = 0; ntog = 0;
        cs_first = 0; cs_last = 0; cs_cnt = 0;
        ld_first = 0; ld_last = 0; ld_cnt = 0;
        done_first = 0; done_last = 0; done_n = 0;
        prev_sclk = o_sclk;
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
        if (o_sclk !== prev_sclk) ntog++;
        if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
            bits = {bits[14:0], o_sdi};
            nrise++;
        end
        prev_sclk = o_sclk;
        if (o_csn === 1'b0) begin
            if (cs_first == 0) cs_first = cyc;
            cs_last = cyc; cs_cnt++;
        end
        if (o_ldn === 1'b0) begin
            if (ld_first == 0) ld_first = cyc;
            ld_last = cyc; ld_cnt++;
        end
        if (o_done === 1'b1) begin
            if (done_first == 0) done_first = cyc;
            done_last = cyc; done_n++;
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        mon_clr();
        step(); step();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_ovr",  32'(o_ovr),  32'd0);
        chk("rst_sclk", 32'(o_sclk), 32'd0);
        chk("rst_sdi",  32'(o_sdi),  32'd0);
        chk("rst_csn",  32'(o_csn),  32'd1);
        chk("rst_ldn",  32'(o_ldn),  32'd1);
        chk("rst_b_csn", 32'(csn_b), 32'd1);
        RST = 1'b0;
        step(); step();

        // T1: CH=1, 0xABC
        ch_a = 1'b1; data_a = 12'hABC; load_a = 1'b1;
        mon_clr(); step();
        load_a = 1'b0; ch_a = 1'b0; data_a = 12'h000;
        chk("t1_busy_c1", 32'(o_busy), 32'd1);
        chk("t1_csn_c1",  32'(o_csn),  32'd0);
        chk("t1_sdi_c1",  32'(o_sdi),  32'd1);
        chk("t1_sclk_c1", 32'(o_sclk), 32'd0);
        run_to(136);
        chk("t1_done_c136", 32'(o_done), 32'd0);
        step();
        chk("t1_done_c137", 32'(o_done), 32'd1);
        chk("t1_busy_c137", 32'(o_busy), 32'd0);
        chk("t1_bits",     32'(bits), 32'h8ABC);
        chk("t1_nrise",    nrise,     32'd16);
        chk("t1_cs_first", cs_first,  32'd1);
        chk("t1_cs_last",  cs_last,   32'd128);
        chk("t1_cs_cnt",   cs_cnt,    32'd128);
        chk("t1_ld_first", ld_first,  32'd133);
        chk("t1_ld_last",  ld_last,   32'd136);
        chk("t1_ld_cnt",   ld_cnt,    32'd4);
        chk("t1_done_cyc", done_first, 32'd137);

        // T2: load in FIN cycle, CH=0, 0x001
        ch_a = 1'b0; data_a = 12'h001; load_a = 1'b1;
        mon_clr(); step();
        load_a = 1'b0;
        chk("t2_csn_c1",  32'(o_csn),  32'd0);
        chk("t2_busy_c1", 32'(o_busy), 32'd1);
        chk("t2_sdi_c1",  32'(o_sdi),  32'd0);
        run_to(138);
        chk("t2_bits",     32'(bits),  32'h0001);
        chk("t2_nrise",    nrise,      32'd16);
        chk("t2_done_cyc", done_first, 32'd137);
        chk("t2_done_n",   done_n,     32'd1);
        chk("t2_ovr",      32'(o_ovr), 32'd0);
        chk("t2_idle_busy", 32'(o_busy), 32'd0);
        chk("t2_idle_csn",  32'(o_csn),  32'd1);

        // T3: overrun pulse at cycle 50
        ch_a = 1'b0; data_a = 12'h3C5; load_a = 1'b1;
        mon_clr(); step();
        load_a = 1'b0;
        run_to(50);
        chk("t3_ovr_pre", 32'(o_ovr), 32'd0);
        ch_a = 1'b1; data_a = 12'hFFF; load_a = 1'b1;
        step();
        load_a = 1'b0;
        chk("t3_ovr_set", 32'(o_ovr), 32'd1);
        run_to(138);
        chk("t3_bits",     32'(bits),  32'h03C5);
        chk("t3_done_cyc", done_first, 32'd137);
        chk("t3_ovr_end",  32'(o_ovr), 32'd1);

        // T4: async reset mid-shift at cycle 60
        ch_a = 1'b1; data_a = 12'h777; load_a = 1'b1;
        mon_clr(); step();
        load_a = 1'b0;
        run_to(60);
        chk("t4_busy_pre", 32'(o_busy), 32'd1);
        chk("t4_sdi_pre",  32'(o_sdi),  32'd1);
        chk("t4_ovr_sticky", 32'(o_ovr), 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("t4_rst_csn",  32'(o_csn),  32'd1);
        chk("t4_rst_sclk", 32'(o_sclk), 32'd0);
        chk("t4_rst_sdi",  32'(o_sdi),  32'd0);
        chk("t4_rst_busy", 32'(o_busy), 32'd0);
        chk("t4_rst_ovr",  32'(o_ovr),  32'd0);
        chk("t4_rst_ldn",  32'(o_ldn),  32'd1);
        step(); step();
        RST = 1'b0;
        step();
        ch_a = 1'b0; data_a = 12'h555; load_a = 1'b1;
        mon_clr(); step();
        load_a = 1'b0;
        run_to(138);
        chk("t4_bits",     32'(bits),  32'h0555);
        chk("t4_nrise",    nrise,      32'd16);
        chk("t4_done_cyc", done_first, 32'd137);
        chk("t4_cs_cnt",   cs_cnt,     32'd128);

        // T5: CLK_DIV=1 instance
        sel = 1'b1;
        ch_b = 1'b0; data_b = 12'hFFF; load_b = 1'b1;
        mon_clr(); step();
        load_b = 1'b0;
        run_to(36);
        chk("t5_bits",     32'(bits),  32'h0FFF);
        chk("t5_nrise",    nrise,      32'd16);
        chk("t5_ntog",     ntog,       32'd32);
        chk("t5_cs_first", cs_first,   32'd1);
        chk("t5_cs_last",  cs_last,    32'd32);
        chk("t5_ld_first", ld_first,   32'd34);
        chk("t5_ld_cnt",   ld_cnt,     32'd1);
        chk("t5_done_cyc", done_first, 32'd35);
        chk("t5_done_n",   done_n,     32'd1);

        // T6: LOAD held for 300 cycles
        sel = 1'b0;
        ch_a = 1'b1; data_a = 12'h123; load_a = 1'b1;
        mon_clr(); step();
        chk("t6_ovr_c1", 32'(o_ovr), 32'd0);
        step();
        chk("t6_ovr_c2", 32'(o_ovr), 32'd1);
        run_to(274);
        chk("t6_done_n",     done_n,     32'd2);
        chk("t6_done_first", done_first, 32'd137);
        chk("t6_done_last",  done_last,  32'd274);
        chk("t6_bits",       32'(bits),  32'h8123);
        chk("t6_nrise",      nrise,      32'd32);
        chk("t6_cs_cnt",     cs_cnt,     32'd256);
        chk("t6_ld_cnt",     ld_cnt,     32'd8);
        run_to(300);
        load_a = 1'b0;
        run_to(420);
        chk("t6_done_n_end",  done_n,     32'd3);
        chk("t6_done_last3",  done_last,  32'd411);
        chk("t6_busy_end",    32'(o_busy), 32'd0);
        chk("t6_ovr_end",     32'(o_ovr),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tub_dac_loader.md
Name: tub_dac_loader

Overview:
- Serial loader for the dual 12-bit threshold DAC on the TUB.
- The DAC outputs feed the lt1364 buffer stage, which drives the analog thresholds.
- Takes a parallel (channel, code) request from board control logic, shifts a 16-bit frame MSB-first over a 3-wire bus, then pulses the DAC load strobe.
- Generates the digital drive for the analog channels that the lt1364 model buffers.

Parameters:
- DATA_WIDTH, 12: DAC code width. The frame is fixed at 16 bits, so DATA_WIDTH must be 12 or less.
- CLK_DIV, 4: CLK cycles per SCLK half-period. Minimum 1; 0 is illegal.

Ports:
- CLK, input, 1: system clock. All logic is on the rising edge.
- RST, input, 1: asynchronous active-high reset.
- LOAD, input, 1: request strobe. Sampled only when BUSY=0.
- CH, input, 1: DAC channel select (0 = A, 1 = B).
- DATA, input, DATA_WIDTH: DAC code.
- BUSY, output, 1: transfer in progress.
- DONE, output, 1: single-cycle completion pulse.
- OVERRUN, output, 1: sticky flag, set when LOAD arrives while BUSY=1.
- DAC_SCLK, output, 1: serial clock. The DAC samples DAC_SDI on the rising edge.
- DAC_SDI, output, 1: serial data.
- DAC_CS_N, output, 1: chip select, active low.
- DAC_LD_N, output, 1: DAC latch strobe, active low.

Behaviour:
- Reset values, applied immediately when RST is asserted, including mid-transfer:
  - BUSY=0, DONE=0, OVERRUN=0.
  - DAC_SCLK=0, DAC_SDI=0, DAC_CS_N=1, DAC_LD_N=1.
  - State=IDLE.
  - No partial frame resumes after reset; the next LOAD starts a fresh frame.
- Frame format: {CH, 3'b000, DATA zero-extended to 12 bits}, transmitted bit 15 first.
- States: IDLE -> SHIFT -> GAP -> LATCH -> FIN -> IDLE.
- IDLE:
  - LOAD=1 at edge 0 captures CH and DATA into a 16-bit shift register.
  - At the same edge: move to SHIFT, BUSY=1, DAC_CS_N=0, DAC_SDI=frame[15], DAC_SCLK=0.
- SHIFT: lasts 16 bits x 2 x CLK_DIV cycles.
  - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - DAC_SDI updates only on the CLK edge where SCLK returns low.
  - SDI is therefore stable for a full half-period on both sides of each rising SCLK edge.
  - After the 16th high phase: SCLK=0, DAC_CS_N=1, move to GAP.
- GAP: CLK_DIV cycles with DAC_CS_N=1 and DAC_SDI=0.
- LATCH: CLK_DIV cycles with DAC_LD_N=0.
- FIN: one cycle with DONE=1 and BUSY=0, then IDLE.
  - LOAD=1 during FIN is accepted exactly as in IDLE (back-to-back transfers).
- Latency:
  - DONE is asserted in cycle 1 + 34·CLK_DIV after LOAD.
  - With CLK_DIV=4, DONE=1 in cycle 137.
- Counters:
  - Bit counter: 4 bits, 15 down to 0.
  - Divider counter: width $clog2(CLK_DIV)+1. It wraps to 0 on terminal count; there is no other wrap-around.
- OVERRUN:
  - Set when LOAD=1 while BUSY=1. The request is ignored, and the in-flight frame and its data are unaffected.
  - Cleared only by RST.
- Simultaneous events:
  - RST has priority over everything.
  - LOAD coinciding with FIN starts a new transfer and does not set OVERRUN.
- CH and DATA are don't-care except at the capture edge.

Decomposition:
- Package tub_dac_pkg holds:
  - FRAME_W=16 and CH_BIT=15.
  - The state enum: IDLE, SHIFT, GAP, LATCH, FIN.
  - Function make_frame(ch, data).
- Sub-module tub_dac_tick (parameter CLK_DIV): a free-running divider.
  - Outputs a 1-cycle tick every CLK_DIV cycles.
  - Restarts on a start input.
- The main FSM consumes the ticks.

Test Plan:
1. CLK_DIV=4. LOAD with CH=1, DATA=12'hABC -> 16 SCLK rising edges sample 1000_1010_1011_1100; CS_N low cycles 1–128; LD_N low cycles 133–136; DONE=1 in cycle 137 only.
2. LOAD again in the FIN cycle, CH=0, DATA=12'h001 -> second frame starts with no idle gap; sampled bits are 0x0001; OVERRUN stays 0.
3. LOAD pulsed at cycle 50 of a transfer -> first frame bits unchanged; OVERRUN=1 and stays 1 until RST.
4. Assert RST at cycle 60 mid-SHIFT -> same cycle (async): CS_N=1, SCLK=0, SDI=0, BUSY=0. After release, LOAD with 12'h555 -> complete fresh frame 0x0555 is sent.
5. CLK_DIV=1, DATA=12'hFFF, CH=0 -> SCLK toggles every CLK; DONE in cycle 35; frame 0x0FFF.
6. Hold LOAD=1 continuously for 300 cycles -> back-to-back frames each with identical timing; OVERRUN=1 after the first busy-cycle sample.
